stream_mux_rr: RTL and testbench

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_rr.sv | 116 +++++++++++
 tb/tb_stream_mux_rr.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// Round-robin N:1 stream multiplexer with packet locking and a registered output stage.
// A channel that starts a multi-beat packet keeps the grant until its last beat is taken.
module stream_mux_rr #(
  parameter  int WIDTH = 4,
  parameter  int N     = 4,
  localparam int SW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_last,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [SW-1:0]    out_sel,
  input  logic             out_ready
);

  // Handshake: a beat moves on any interface when valid && ready are both high at a
  // rising edge. in_ready is combinational from grant state, in_valid and out_ready only;
  // out_valid/out_data/out_last/out_sel are registers that hold while out_ready is low.

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SW-1:0]    r_out_sel;
  logic [SW-1:0]    r_ptr;
  logic             r_lock;
  logic [SW-1:0]    r_lock_ch;

  logic             w_load;
  logic             w_found;
  logic [SW-1:0]    w_gnt;
  logic [N-1:0]     w_ready;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;
  logic             w_last;

  assign w_load = !r_out_valid || out_ready;

  // Locked: only the packet owner is eligible. Unlocked: first valid after r_ptr, wrapping.
  always_comb begin : grant_search
    logic [SW-1:0] v_idx;
    v_idx   = '0;
    w_found = 1'b0;
    w_gnt   = '0;
    if (r_lock) begin
      w_gnt   = r_lock_ch;
      w_found = in_valid[r_lock_ch];
    end else begin
      for (int k = 1; k <= N; k++) begin
        v_idx = SW'((int'(r_ptr) + k) % N);
        if (!w_found && in_valid[v_idx]) begin
          w_found = 1'b1;
          w_gnt   = v_idx;
        end
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (!rst && w_load && w_found) begin
      w_ready[w_gnt] = 1'b1;
    end
  end

  assign w_xfer   = !rst && w_load && w_found;
  assign in_ready = w_ready;

  always_comb begin
    w_data = '0;
    w_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == SW'(i)) begin
        w_data = in_data[i*WIDTH +: WIDTH];
        w_last = in_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
      r_lock      <= 1'b0;
      r_lock_ch   <= '0;
      r_ptr       <= SW'(N - 1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_last  <= w_last;
      r_out_sel   <= w_gnt;
      // The last beat releases the lock and becomes the new round-robin reference.
      if (w_last) begin
        r_lock <= 1'b0;
        r_ptr  <= w_gnt;
      end else begin
        r_lock    <= 1'b1;
        r_lock_ch <= w_gnt;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (N=4, WIDTH=4): expected beats are queued at issue
// time and a negedge monitor pops and compares each accepted output beat.
module tb_stream_mux_rr;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int SW = 2;
  localparam int EW = SW + 1 + W;

  logic             clk;
  logic             rst;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_last;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic [SW-1:0]    out_sel;
  logic             out_ready;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  stream_mux_rr #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [SW-1:0] sel, input logic last,
                                   input logic [W-1:0] data);
    exp_q.push_back({sel, last, data});
  endfunction

  // One cycle: drive inputs, check in_ready mid-cycle, advance past the edge.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic [N-1:0] l,
                      input logic ordy, input logic [N-1:0] exp_rdy, input string name);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    @(negedge clk);
    chk(name, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got sel=%0d last=%0d data=%0h, expected none",
                 out_sel, out_last, out_data);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({out_sel, out_last, out_data} !== e) begin
          n_err++;
          $display("FAIL beat: got sel=%0d last=%0d data=%0h, expected sel=%0d last=%0d data=%0h",
                   out_sel, out_last, out_data, e[EW-1 -: SW], e[W], e[W-1:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_last",  32'(out_last),  32'h0);
    chk("rst_out_sel",   32'(out_sel),   32'h0);
    rst      = 1'b0;
    in_valid = '0;

    // single beat on ch0
    push_exp(2'd0, 1'b1, 4'hA);
    step(4'b0001, 16'h000A, 4'hF, 1'b1, 4'b0001, "t1_rdy");
    chk("t1_out_valid", 32'(out_valid), 32'h1);
    step(4'b0000, 16'h0000, 4'hF, 1'b1, 4'b0000, "t1_idle");

    // all channels valid, single-beat packets: strict rotation, no bubbles
    do_reset();
    for (int k = 0; k < 8; k++) begin
      push_exp(2'(k % 4), 1'b1, 4'(k % 4 + 1));
      step(4'hF, 16'h4321, 4'hF, 1'b1, 4'(1 << (k % 4)), "rr_rdy");
      chk("rr_no_bubble", 32'(out_valid), 32'h1);
    end
    step(4'b0000, 16'h0000, 4'hF, 1'b1, 4'b0000, "rr_idle");

    // ch2 3-beat packet while others become valid, then rotation resumes after ch2
    push_exp(2'd2, 1'b0, 4'h5);
    step(4'b0100, 16'h0500, 4'b1011, 1'b1, 4'b0100, "pkt_b1");
    push_exp(2'd2, 1'b0, 4'h6);
    step(4'b0111, 16'h0611, 4'b1011, 1'b1, 4'b0100, "pkt_b2");
    push_exp(2'd2, 1'b1, 4'h7);
    step(4'b1111, 16'h8711, 4'hF, 1'b1, 4'b0100, "pkt_b3");
    push_exp(2'd3, 1'b1, 4'h8);
    step(4'b1111, 16'h8711, 4'hF, 1'b1, 4'b1000, "pkt_next3");
    push_exp(2'd0, 1'b1, 4'h1);
    step(4'b1111, 16'h8711, 4'hF, 1'b1, 4'b0001, "pkt_next0");
    step(4'b0000, 16'h0000, 4'hF, 1'b1, 4'b0000, "pkt_idle");

    // backpressure: held beat stays stable, then drains with a same-cycle reload
    push_exp(2'd1, 1'b1, 4'h9);
    step(4'b0010, 16'h0090, 4'hF, 1'b1, 4'b0010, "bp_load");
    for (int k = 0; k < 5; k++) begin
      step(4'b0011, 16'h009B, 4'hF, 1'b0, 4'b0000, "bp_hold_rdy");
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      chk("bp_hold_data",  32'(out_data),  32'h9);
      chk("bp_hold_sel",   32'(out_sel),   32'h1);
    end
    push_exp(2'd0, 1'b1, 4'hB);
    step(4'b0011, 16'h009B, 4'hF, 1'b1, 4'b0001, "bp_drain_rdy");
    chk("bp_reload_valid", 32'(out_valid), 32'h1);
    chk("bp_reload_sel",   32'(out_sel),   32'h0);
    step(4'b0000, 16'h0000, 4'hF, 1'b1, 4'b0000, "bp_idle");

    // ch1 locked, drops valid for two cycles while ch3 waits
    push_exp(2'd1, 1'b0, 4'h1);
    step(4'b0010, 16'h0010, 4'b1101, 1'b1, 4'b0010, "lk_b1");
    step(4'b1000, 16'h3000, 4'hF, 1'b1, 4'b0000, "lk_gap1");
    step(4'b1000, 16'h3000, 4'hF, 1'b1, 4'b0000, "lk_gap2");
    chk("lk_bubble", 32'(out_valid), 32'h0);
    push_exp(2'd1, 1'b1, 4'h2);
    step(4'b1010, 16'h3020, 4'hF, 1'b1, 4'b0010, "lk_b2");
    push_exp(2'd3, 1'b1, 4'h3);
    step(4'b1000, 16'h3000, 4'hF, 1'b1, 4'b1000, "lk_ch3");
    step(4'b0000, 16'h0000, 4'hF, 1'b1, 4'b0000, "lk_idle");

    // reset mid-packet discards the held beat and the lock
    step(4'b0100, 16'h0C00, 4'b1011, 1'b0, 4'b0100, "mr_b1");
    chk("mr_held_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    step(4'b0111, 16'h0CD0, 4'b1011, 1'b0, 4'b0000, "mr_rst_rdy");
    rst = 1'b0;
    chk("mr_out_valid", 32'(out_valid), 32'h0);
    chk("mr_out_data",  32'(out_data),  32'h0);
    chk("mr_out_sel",   32'(out_sel),   32'h0);
    push_exp(2'd1, 1'b1, 4'hD);
    step(4'b0110, 16'h0CD0, 4'hF, 1'b1, 4'b0010, "mr_regrant");
    step(4'b0000, 16'h0000, 4'hF, 1'b1, 4'b0000, "mr_idle1");
    step(4'b0000, 16'h0000, 4'hF, 1'b1, 4'b0000, "mr_idle2");

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
